// File: rtl/bit_permute_pkg.sv
// Shared definitions for the bit-permute pipeline: operation modes and default sizes.
package bit_permute_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    MODE_PASS    = 2'd0,
    MODE_BITREV  = 2'd1,
    MODE_BYTEREV = 2'd2,
    MODE_ROTL    = 2'd3
  } mode_e;

endpackage

// File: rtl/bit_permute_if.sv
// Upstream/downstream handshake bundle for bit_permute_pipe; the pipe sits on the slave side.
interface bit_permute_if
  import bit_permute_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);
  localparam int ROT_W = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_mode;
  logic [ROT_W-1:0] in_rot;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] beat_cnt;

  modport slave (
    input  in_valid, in_data, in_mode, in_rot, out_ready,
    output in_ready, out_valid, out_data, beat_cnt
  );

  modport master (
    output in_valid, in_data, in_mode, in_rot, out_ready,
    input  in_ready, out_valid, out_data, beat_cnt
  );
endinterface

// File: rtl/bit_permute_core.sv
// Purely combinational data transform: pass, bit-reverse, byte-reverse or rotate-left.
module bit_permute_core
  import bit_permute_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0]         data,
  input  logic [1:0]               mode,
  input  logic [$clog2(WIDTH)-1:0] rot,
  output logic [WIDTH-1:0]         result
);
  localparam int NBYTES = WIDTH / 8;

  logic [31:0]      rot_mod;
  logic [WIDTH-1:0] bitrev;
  logic [WIDTH-1:0] byterev;
  logic [WIDTH-1:0] rotl;

  // Rotate amount can exceed WIDTH-1 when WIDTH is not a power of two.
  assign rot_mod = 32'(rot) % 32'(WIDTH);
  assign rotl    = (data << rot_mod) | (data >> (32'(WIDTH) - rot_mod));

  always_comb begin
    bitrev  = '0;
    byterev = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bitrev[i] = data[WIDTH-1-i];
    end
    for (int k = 0; k < NBYTES; k++) begin
      byterev[8*k +: 8] = data[8*(NBYTES-1-k) +: 8];
    end
  end

  always_comb begin
    result = data;
    case (mode_e'(mode))
      MODE_PASS:    result = data;
      MODE_BITREV:  result = bitrev;
      MODE_BYTEREV: result = byterev;
      MODE_ROTL:    result = rotl;
      default:      result = data;
    endcase
  end

endmodule

// File: rtl/bit_permute_pipe.sv
// One-cycle transform pipe with output register plus skid register; in_ready is registered
// and equals "skid empty", so upstream never sees a combinational path from out_ready.
module bit_permute_pipe
  import bit_permute_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  bit_permute_if.slave bus
);
  localparam int ROT_W = $clog2(WIDTH);

  logic [ROT_W-1:0] rot_in;
  logic [WIDTH-1:0] xf_dat;

  logic             out_vld_q, out_vld_d;
  logic [WIDTH-1:0] out_dat_q, out_dat_d;
  logic             skid_vld_q, skid_vld_d;
  logic [WIDTH-1:0] skid_dat_q, skid_dat_d;
  logic             in_rdy_q, in_rdy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, deliver;

  assign rot_in = bus.in_rot;

  bit_permute_core #(.WIDTH(WIDTH)) u_core (
    .data   (bus.in_data),
    .mode   (bus.in_mode),
    .rot    (rot_in),
    .result (xf_dat)
  );

  assign accept  = bus.in_valid & in_rdy_q;
  assign deliver = out_vld_q & bus.out_ready;

  always_comb begin
    out_vld_d  = out_vld_q;
    out_dat_d  = out_dat_q;
    skid_vld_d = skid_vld_q;
    skid_dat_d = skid_dat_q;
    cnt_d      = cnt_q;

    if (deliver) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (skid_vld_q) begin
      // in_ready is low here, so no new beat can arrive this cycle.
      if (deliver) begin
        out_dat_d  = skid_dat_q;
        skid_vld_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_vld_q || deliver) begin
        out_vld_d = 1'b1;
        out_dat_d = xf_dat;
      end else begin
        skid_vld_d = 1'b1;
        skid_dat_d = xf_dat;
      end
    end else if (deliver) begin
      out_vld_d = 1'b0;
    end

    in_rdy_d = ~skid_vld_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_dat_q  <= '0;
      skid_vld_q <= 1'b0;
      skid_dat_q <= '0;
      in_rdy_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_dat_q  <= out_dat_d;
      skid_vld_q <= skid_vld_d;
      skid_dat_q <= skid_dat_d;
      in_rdy_q   <= in_rdy_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready  = in_rdy_q;
  assign bus.out_valid = out_vld_q;
  assign bus.out_data  = out_dat_q;
  assign bus.beat_cnt  = cnt_q;

endmodule

// File: tb/tb_bit_permute_pipe.sv
// Directed and randomised checks of bit_permute_pipe at WIDTH=8 and WIDTH=32/CNT_W=4.
module tb_bit_permute_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bit_permute_if #(.WIDTH(8),  .CNT_W(16)) bus_a ();
  bit_permute_if #(.WIDTH(32), .CNT_W(4))  bus_b ();

  bit_permute_pipe #(.WIDTH(8),  .CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  bit_permute_pipe #(.WIDTH(32), .CNT_W(4))  dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] ref8(input logic [7:0] d, input logic [1:0] m, input logic [2:0] r);
    logic [7:0] o;
    o = d;
    case (m)
      2'd1: o = {d[0], d[1], d[2], d[3], d[4], d[5], d[6], d[7]};
      2'd3: if (r != 3'd0) o = (d << r) | (d >> (4'd8 - {1'b0, r}));
      default: o = d;
    endcase
    return o;
  endfunction

  task automatic drive_a(input logic v, input logic [7:0] d, input logic [1:0] m, input logic [2:0] r);
    bus_a.in_valid = v;
    bus_a.in_data  = d;
    bus_a.in_mode  = m;
    bus_a.in_rot   = r;
  endtask

  task automatic drive_b(input logic v, input logic [31:0] d, input logic [1:0] m, input logic [4:0] r);
    bus_b.in_valid = v;
    bus_b.in_data  = d;
    bus_b.in_mode  = m;
    bus_b.in_rot   = r;
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] exp_d;
    logic [7:0] prev_d;
    logic       prev_stall;
    int         acc, dlv, cyc;

    rst_n = 1'b0;
    drive_a(1'b0, 8'h00, 2'd0, 3'd0);
    drive_b(1'b0, 32'h0, 2'd0, 5'd0);
    bus_a.out_ready = 1'b0;
    bus_b.out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_ovalid", 64'(bus_a.out_valid), 64'd0);
    chk("rst_iready", 64'(bus_a.in_ready),  64'd0);
    chk("rst_odata",  64'(bus_a.out_data),  64'd0);
    chk("rst_cnt",    64'(bus_a.beat_cnt),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_iready_low", 64'(bus_a.in_ready), 64'd0);
    @(negedge clk);
    chk("rel_iready_high", 64'(bus_a.in_ready), 64'd1);

    // Four modes on 0xB1, back to back
    bus_a.out_ready = 1'b1;
    drive_a(1'b1, 8'hB1, 2'd0, 3'd0);
    @(negedge clk);
    chk("m0_valid", 64'(bus_a.out_valid), 64'd1);
    chk("m0_data",  64'(bus_a.out_data),  64'hB1);
    drive_a(1'b1, 8'hB1, 2'd1, 3'd0);
    @(negedge clk);
    chk("m1_data", 64'(bus_a.out_data), 64'h8D);
    drive_a(1'b1, 8'hB1, 2'd2, 3'd0);
    @(negedge clk);
    chk("m2_data", 64'(bus_a.out_data), 64'hB1);
    drive_a(1'b1, 8'hB1, 2'd3, 3'd3);
    @(negedge clk);
    chk("m3_data",  64'(bus_a.out_data),  64'h8D);
    chk("m3_valid", 64'(bus_a.out_valid), 64'd1);
    drive_a(1'b0, 8'h00, 2'd0, 3'd0);
    @(negedge clk);
    chk("m_cnt4",   64'(bus_a.beat_cnt),  64'd4);
    chk("m_idle",   64'(bus_a.out_valid), 64'd0);

    // 32-bit byte reverse and rotate, then counter wrap at CNT_W=4
    bus_b.out_ready = 1'b1;
    drive_b(1'b1, 32'h11223344, 2'd2, 5'd0);
    @(negedge clk);
    chk("w32_byterev", 64'(bus_b.out_data), 64'h44332211);
    drive_b(1'b1, 32'h11223344, 2'd3, 5'd8);
    @(negedge clk);
    chk("w32_rotl8", 64'(bus_b.out_data), 64'h22334411);
    for (int i = 0; i < 15; i++) begin
      drive_b(1'b1, 32'(i), 2'd0, 5'd0);
      @(negedge clk);
    end
    chk("w32_last", 64'(bus_b.out_data), 64'h0E);
    drive_b(1'b0, 32'h0, 2'd0, 5'd0);
    @(negedge clk);
    chk("cnt_wrap17", 64'(bus_b.beat_cnt), 64'd1);

    // Backpressure fills the skid register
    bus_a.out_ready = 1'b0;
    drive_a(1'b1, 8'h01, 2'd0, 3'd0);
    @(negedge clk);
    chk("bp_rdy1",  64'(bus_a.in_ready), 64'd1);
    chk("bp_data1", 64'(bus_a.out_data), 64'h01);
    drive_a(1'b1, 8'h02, 2'd0, 3'd0);
    @(negedge clk);
    chk("bp_rdy_drop", 64'(bus_a.in_ready), 64'd0);
    chk("bp_hold1",    64'(bus_a.out_data), 64'h01);
    drive_a(1'b1, 8'h03, 2'd0, 3'd0);
    @(negedge clk);
    chk("bp_rdy_still", 64'(bus_a.in_ready), 64'd0);
    chk("bp_hold2",     64'(bus_a.out_data), 64'h01);
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_data2",   64'(bus_a.out_data), 64'h02);
    chk("bp_rdy_rec", 64'(bus_a.in_ready), 64'd1);
    @(negedge clk);
    chk("bp_data3", 64'(bus_a.out_data),  64'h03);
    chk("bp_vld3",  64'(bus_a.out_valid), 64'd1);
    drive_a(1'b0, 8'h00, 2'd0, 3'd0);
    @(negedge clk);
    chk("bp_empty", 64'(bus_a.out_valid), 64'd0);
    chk("bp_cnt7",  64'(bus_a.beat_cnt),  64'd7);

    // Random traffic against a reference queue
    acc = 0; dlv = 0; cyc = 0;
    prev_stall = 1'b0;
    prev_d = 8'h00;
    while ((acc < 10000 || q.size() != 0) && cyc < 80000) begin
      @(negedge clk);
      cyc++;
      if (prev_stall) begin
        chk("rnd_hold_vld",  64'(bus_a.out_valid), 64'd1);
        chk("rnd_hold_data", 64'(bus_a.out_data),  64'(prev_d));
      end
      drive_a((acc < 10000) ? 1'($urandom_range(0, 1)) : 1'b0,
              8'($urandom), 2'($urandom), 3'($urandom));
      bus_a.out_ready = 1'($urandom_range(0, 1));
      if (bus_a.out_valid && bus_a.out_ready) begin
        if (q.size() == 0) begin
          chk("rnd_extra_beat", 64'(q.size()), 64'd1);
        end else begin
          exp_d = q.pop_front();
          chk("rnd_data", 64'(bus_a.out_data), 64'(exp_d));
        end
        dlv++;
      end
      if (bus_a.in_valid && bus_a.in_ready) begin
        q.push_back(ref8(bus_a.in_data, bus_a.in_mode, bus_a.in_rot));
        acc++;
      end
      prev_stall = bus_a.out_valid && !bus_a.out_ready;
      prev_d     = bus_a.out_data;
    end
    chk("rnd_delivered", 64'(dlv),      64'd10000);
    chk("rnd_q_empty",   64'(q.size()), 64'd0);
    drive_a(1'b0, 8'h00, 2'd0, 3'd0);
    bus_a.out_ready = 1'b0;
    @(negedge clk);

    // Asynchronous reset with both registers occupied
    drive_a(1'b1, 8'hAA, 2'd0, 3'd0);
    @(negedge clk);
    drive_a(1'b1, 8'hBB, 2'd1, 3'd0);
    @(negedge clk);
    drive_a(1'b0, 8'h00, 2'd0, 3'd0);
    chk("ar_full_rdy", 64'(bus_a.in_ready),  64'd0);
    chk("ar_full_vld", 64'(bus_a.out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_vld",  64'(bus_a.out_valid), 64'd0);
    chk("ar_cnt",  64'(bus_a.beat_cnt),  64'd0);
    chk("ar_data", 64'(bus_a.out_data),  64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus_a.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ar_no_stale", 64'(bus_a.out_valid), 64'd0);
    end
    chk("ar_rdy_back", 64'(bus_a.in_ready), 64'd1);
    chk("ar_cnt_held", 64'(bus_a.beat_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
